// File: rtl/spi_reg_pkg.sv
// Shared frame layout and register map for the SPI register peripheral.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;
  localparam int RW_BIT     = 15;
  localparam int ADDR_W     = 7;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS + 1);

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_PWM_DUTY  = 4;

  function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_BITS-1:0] frame);
    return frame[RW_BIT-1 -: ADDR_W];
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit; depth set by DEPTH.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) stages <= '0;
    else     stages <= {stages[DEPTH-2:0], d};
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 register peripheral: 16-bit frames write a bank of 8-bit registers.
// Define SPI_READBACK_EN to return the addressed register on cipo during read frames.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_err
);

  logic sclk_s, ncs_s, copi_s;
  logic sclk_d, ncs_d;
  logic sclk_rise, ncs_rise, ncs_fall;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_ncs  (.clk(clk), .rst(rst), .d(ncs),  .q(ncs_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_copi (.clk(clk), .rst(rst), .d(copi), .q(copi_s));

  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  // armed is only set by a clean ncs fall, so bits seen after reset mid-frame are dropped
  logic                  armed;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;

  logic              len_ok, addr_ok, is_write, do_write, do_err;
  logic [ADDR_W-1:0] addr;

  assign addr     = frame_addr(shift_reg);
  assign len_ok   = (bit_cnt == CNT_W'(FRAME_BITS));
  assign addr_ok  = (addr < ADDR_W'(NUM_REGS));
  assign is_write = shift_reg[RW_BIT];
  assign do_write = len_ok & is_write & addr_ok;
`ifdef SPI_READBACK_EN
  assign do_err   = ~len_ok | ~addr_ok;
`else
  assign do_err   = ~len_ok | (is_write & ~addr_ok);
`endif

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
      armed     <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      if (ncs_fall) begin
        armed     <= 1'b1;
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (armed && sclk_rise && !ncs_s) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s};
        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
      end
      if (ncs_rise && armed) begin
        armed <= 1'b0;
        if (do_write) begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= shift_reg[7:0];
        end else if (do_err) begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  logic [7:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && wr_addr == ADDR_W'(i)) regs[i] <= wr_data;
      end
    end
  end

  assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs[ADDR_PWM_DUTY];

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] tx_shift;
  logic [7:0] rd_value;

  assign sclk_fall = ~sclk_s & sclk_d;

  // after 8 bits the low byte of shift_reg holds {R/W, address}
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_reg[ADDR_W-1:0] == ADDR_W'(i)) rd_value = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ncs_fall) begin
      tx_shift <= '0;
    end else if (armed && sclk_fall && !ncs_s) begin
      if (bit_cnt == CNT_W'(CMD_BITS) && !shift_reg[CMD_BITS-1]) tx_shift <= rd_value;
      else if (bit_cnt > CNT_W'(CMD_BITS)) tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  assign cipo    = tx_shift[7];
  assign cipo_oe = armed & ~ncs_s;
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral; readback checks follow SPI_READBACK_EN.
module tb_spi_reg_peripheral;

  localparam int SYNC_STAGES = 2;
  localparam int NUM_REGS    = 5;
  localparam int HALF        = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       ncs = 1'b1;
  logic       copi = 1'b0;
  logic       cipo, cipo_oe, frame_err;
  logic [7:0] r0, r1, r2, r3, r4;

  int         n_checks = 0;
  int         n_fail = 0;
  int         err_pulses = 0;
  logic [7:0] model [NUM_REGS];

  spi_reg_peripheral #(.SYNC_STAGES(SYNC_STAGES), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  function automatic logic [7:0] reg_port(input int i);
    case (i)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      default: return r4;
    endcase
  endfunction

  // Reference: what a 16-bit frame means, independent of how the DUT counts bits
  task automatic model_frame(input logic [16:0] word, input int nbits,
                             output int exp_err, output logic [7:0] exp_rx);
    logic       rw;
    int         a;
    exp_err = 0;
    exp_rx  = 8'h00;
    if (nbits != 16) begin
      exp_err = 1;
      return;
    end
    rw = word[15];
    a  = int'(word[14:8]);
    if (rw) begin
      if (a < NUM_REGS) model[a] = word[7:0];
      else exp_err = 1;
    end else begin
`ifdef SPI_READBACK_EN
      if (a < NUM_REGS) exp_rx = model[a];
      else exp_err = 1;
`endif
    end
  endtask

  task automatic spi_shift(input logic [16:0] word, input int nbits, output logic [7:0] rx,
                           output int oe_hi, output int cipo_hi);
    int idx;
    rx = 8'h00; oe_hi = 0; cipo_hi = 0;
    @(negedge clk);
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = word[i];
      repeat (HALF) @(negedge clk);
      if (cipo_oe === 1'b1) oe_hi++;
      if (cipo === 1'b1) cipo_hi++;
      idx = nbits - 1 - i;
      if (idx >= 8 && idx < 16) rx = {rx[6:0], cipo};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_end();
    ncs = 1'b1;
    repeat (SYNC_STAGES + 6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NUM_REGS; i++) begin
      model[i] = 8'h00;
      n_checks++;
      if (reg_port(i) !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h expected 00", i, reg_port(i));
      end
    end
    n_checks++;
    if (cipo_oe !== 1'b0 || cipo !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: cipo_oe=%b cipo=%b frame_err=%b expected 0 0 0", cipo_oe, cipo, frame_err);
    end
    repeat (SYNC_STAGES + 4) @(negedge clk);
  endtask

  // Drives one frame and checks registers, error pulses and the cipo side
  task automatic test_frame(input string name, input logic [16:0] word, input int nbits);
    int         exp_err, e0, oe_hi, cipo_hi;
    logic [7:0] exp_rx, rx;
    e0 = err_pulses;
    model_frame(word, nbits, exp_err, exp_rx);
    spi_shift(word, nbits, rx, oe_hi, cipo_hi);
    spi_end();
    for (int i = 0; i < NUM_REGS; i++) begin
      n_checks++;
      if (reg_port(i) !== model[i]) begin
        n_fail++;
        $display("FAIL %s reg%0d: got %h expected %h", name, i, reg_port(i), model[i]);
      end
    end
    n_checks++;
    if (err_pulses - e0 != exp_err) begin
      n_fail++;
      $display("FAIL %s frame_err: got %0d pulses expected %0d", name, err_pulses - e0, exp_err);
    end
`ifdef SPI_READBACK_EN
    n_checks++;
    if (oe_hi != nbits) begin
      n_fail++;
      $display("FAIL %s cipo_oe: high on %0d bits expected %0d", name, oe_hi, nbits);
    end
    if (nbits == 16 && word[15] == 1'b0) begin
      n_checks++;
      if (rx !== exp_rx) begin
        n_fail++;
        $display("FAIL %s readback: got %h expected %h", name, rx, exp_rx);
      end
    end
`else
    n_checks++;
    if (oe_hi != 0 || cipo_hi != 0) begin
      n_fail++;
      $display("FAIL %s cipo_idle: oe high %0d, cipo high %0d, expected 0 0", name, oe_hi, cipo_hi);
    end
`endif
  endtask

  task automatic test_write();
    test_frame("write_80F0", 17'h080F0, 16);
    test_frame("write_8480", 17'h08480, 16);
  endtask

  task automatic test_invalid_addr();
    test_frame("bad_addr_9055", 17'h09055, 16);
  endtask

  task automatic test_framing();
    logic [16:0] w;
    w = 17'h08311;
    test_frame("short_15", w >> 1, 15);
    test_frame("long_17", {w[15:0], 1'b1}, 17);
  endtask

  task automatic test_idle_sclk();
    for (int i = 0; i < 6; i++) begin
      copi = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    test_frame("after_idle_sclk", 17'h08155, 16);
  endtask

  task automatic test_readback();
    test_frame("write_8237", 17'h08237, 16);
    test_frame("read_0200", 17'h00200, 16);
    test_frame("read_bad_0700", 17'h00700, 16);
  endtask

  task automatic test_latency();
    int         oe_hi, cipo_hi;
    logic [7:0] rx, old_v;
    old_v = model[3];
    spi_shift(17'h083A5, 16, rx, oe_hi, cipo_hi);
    ncs = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    n_checks++;
    if (r3 !== old_v) begin
      n_fail++;
      $display("FAIL latency_early: got %h expected %h", r3, old_v);
    end
    @(negedge clk);
    model[3] = 8'hA5;
    n_checks++;
    if (r3 !== 8'hA5) begin
      n_fail++;
      $display("FAIL latency_update: got %h expected a5", r3);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int         e0, oe_hi, cipo_hi;
    logic [7:0] rx;
    logic [16:0] w;
    w  = 17'h08099;
    e0 = err_pulses;
    spi_shift(w >> 6, 10, rx, oe_hi, cipo_hi);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    spi_shift(w & 17'h0003F, 6, rx, oe_hi, cipo_hi);
    spi_end();
    for (int i = 0; i < NUM_REGS; i++) begin
      n_checks++;
      if (reg_port(i) !== 8'h00) begin
        n_fail++;
        $display("FAIL rst_midframe reg%0d: got %h expected 00", i, reg_port(i));
      end
    end
    n_checks++;
    if (err_pulses != e0) begin
      n_fail++;
      $display("FAIL rst_midframe frame_err: got %0d pulses expected 0", err_pulses - e0);
    end
    test_frame("after_rst_8022", 17'h08022, 16);
  endtask

  task automatic test_random();
    logic [15:0] f;
    int          sel;
    for (int n = 0; n < 30; n++) begin
      f   = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
      sel = $urandom_range(0, 4);
      if (sel == 0)      test_frame("rand_15", {1'b0, f} >> 1, 15);
      else if (sel == 4) test_frame("rand_17", {f, 1'($urandom_range(0, 1))}, 17);
      else               test_frame("rand_16", {1'b0, f}, 16);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_invalid_addr();
    test_framing();
    test_idle_sclk();
    test_readback();
    test_latency();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_peripheral.md
SPI_REG_PERIPHERAL -- requirements
Module: spi_reg_peripheral

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth on sclk/ncs/copi (legal 2..3).
REQ-002 Parameter: NUM_REGS, 5, number of writable registers at addresses 0x00..NUM_REGS-1.
REQ-003 Port: clk  in  1  system clock; all logic on its rising edge; this is the only clock.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: sclk  in  1  SPI clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-006 Port: ncs  in  1  SPI chip select, active low, asynchronous.
REQ-007 Port: copi  in  1  SPI data in, sampled on sclk rising edge, MSB first.
REQ-008 Port: cipo / cipo_oe  out  1/1  SPI data out and its output enable.
REQ-009 Port: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  out  8 each  registers 0x00..0x04.
REQ-010 Port: frame_err  out  1  one-clk pulse when a frame is discarded.

Function
REQ-011 Frame: 16 bits while ncs low; bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-012 sclk, ncs, copi each pass through SYNC_STAGES flops before use; edges are detected on synchronized values only.
REQ-013 Synchronized ncs falling edge clears the bit counter and shift register.
REQ-014 Each synchronized sclk rising edge with ncs low shifts copi into the LSB; the counter increments and saturates at 17.
REQ-015 Synchronized ncs rising edge with count == 16, R/W = 1 and address < NUM_REGS writes the data byte; the register updates on the next clk edge.
REQ-016 Count != 16 at ncs rise (short or long frame) shall discard the frame and pulse frame_err.
REQ-017 Address >= NUM_REGS shall discard the frame and pulse frame_err.
REQ-018 A write frame leaves all non-addressed registers unchanged.
REQ-019 A read frame (R/W = 0) never modifies any register.
REQ-020 sclk edges while ncs high are ignored.
REQ-021 Physical ncs rise to register update latency is SYNC_STAGES+2 clk cycles.
REQ-022 sclk frequency shall not exceed clk/8.

Reset
REQ-023 rst clears all five registers to 0x00, the counter, the shift register and synchronizer flops; it forces cipo=0, cipo_oe=0 and frame_err=0.
REQ-024 rst asserted mid-frame aborts the frame with no write and no frame_err.
REQ-025 After rst deasserts, bits received before the next synchronized ncs falling edge are ignored.

Configuration
REQ-026 Macro SPI_READBACK_EN defined: on a read frame, after the 8th bit the addressed register value is loaded into an output shifter (0x00 if address >= NUM_REGS).
REQ-027 With SPI_READBACK_EN defined, the shifter drives cipo MSB first, changing after each synchronized sclk falling edge for bits 8..15; cipo_oe = 1 while synchronized ncs is low.
REQ-028 With SPI_READBACK_EN defined, an out-of-range read pulses frame_err at ncs rise.
REQ-029 Macro undefined: cipo = 0 and cipo_oe = 0 constantly; a read frame is silently ignored with no frame_err.

Structure
REQ-030 Shared package spi_reg_pkg holds FRAME_BITS = 16, the five register address constants and the R/W bit position.
REQ-031 One sub-module, sync_ff, parameterized by depth, is instantiated once per asynchronous input.

Verification
REQ-032 Reset: rst high 2 cycles -> all register outputs 0x00, cipo_oe = 0, frame_err = 0.
REQ-033 Write: frame 0x80F0 (write addr 0x00 data 0xF0) -> en_reg_out_7_0 = 0xF0, others 0x00.
REQ-034 Write: then frame 0x8480 -> pwm_duty_cycle = 0x80 and en_reg_out_7_0 still 0xF0.
REQ-035 Invalid address: frame 0x9055 (addr 0x10) -> no register change, single frame_err pulse.
REQ-036 Framing: 15-bit frame and 17-bit frame of a valid write -> no change, frame_err each.
REQ-037 Readback: with SPI_READBACK_EN after 0x8237, read frame 0x0200 -> cipo shifts 0x37 on bits 8..15; without the macro -> cipo_oe stays 0; rst at bit 10 of a write -> no update.
